// File: rtl/jvm_exec_unit.sv
// Execution core of the bali Java-bytecode CPU: sequencing FSM plus a registered
// 32-bit evaluation stack. One instruction at a time; op_done pulses with the PC increment.
module jvm_exec_unit #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   op_code,
  input  logic [7:0]                   arg1,
  input  logic [7:0]                   arg2,
  output logic [15:0]                  offset,
  output logic                         op_done,
  output logic                         illegal_op,
  output logic [DW-1:0]                tos,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stack_err
);

  localparam int DEPW = $clog2(DEPTH+1);
  localparam int IW   = $clog2(DEPTH);
  localparam logic [DEPW-1:0] D_ONE  = DEPW'(1);
  localparam logic [DEPW-1:0] D_FULL = DEPW'(DEPTH);
  localparam logic [DEPW-1:0] D_ZERO = DEPW'(0);
  localparam logic [DW-1:0]   W_ZERO = DW'(0);
  localparam logic [DW-1:0]   W_THREE = DW'(3);

  typedef enum logic [2:0] {
    S_DECODE = 3'd0, S_POP2 = 3'd1, S_POP1 = 3'd2,
    S_EXEC   = 3'd3, S_PUSH = 3'd4, S_DONE = 3'd5
  } state_t;

  function automatic logic [1:0] pops_of(input logic [7:0] op);
    case (op)
      8'h57, 8'h74, 8'h99, 8'h9A:                         return 2'd1;
      8'h5F, 8'h60, 8'h64, 8'h68, 8'h7E, 8'h80, 8'h82,
      8'h9F, 8'hA0, 8'hA1:                                return 2'd2;
      default:                                            return 2'd0;
    endcase
  endfunction

  function automatic logic pushes_of(input logic [7:0] op);
    case (op)
      8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
      8'h10, 8'h11, 8'h59, 8'h5F, 8'h60, 8'h64, 8'h68,
      8'h7E, 8'h80, 8'h82, 8'h74:                         return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_exec(input logic [7:0] op);
    case (op)
      8'h60, 8'h64, 8'h68, 8'h7E, 8'h80, 8'h82, 8'h74:    return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [7:0] op);
    case (op)
      8'h00, 8'h57, 8'hA7, 8'h99, 8'h9A, 8'h9F, 8'hA0, 8'hA1: return 1'b1;
      default:                                                return pushes_of(op);
    endcase
  endfunction

  function automatic logic [DW-1:0] alu(input logic [7:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    case (op)
      8'h60:   return a + b;
      8'h64:   return a - b;
      8'h68:   return a * b;
      8'h7E:   return a & b;
      8'h80:   return a | b;
      8'h82:   return a ^ b;
      8'h74:   return W_ZERO - b;
      default: return W_ZERO;
    endcase
  endfunction

  state_t              state_r, state_next_s;
  logic [7:0]          op_r, cur_op_s;
  logic [DW-1:0]       val1_r, val2_r, res_r, top_s, push_val_s;
  logic [DW-1:0]       mem_r [DEPTH];
  logic [DEPW-1:0]     depth_r;
  logic [IW-1:0]       top_idx_s;
  logic                swap_2nd_r, err_r, pop_s, push_s, taken_s;
  logic                op_done_r, illegal_r;
  logic [15:0]         offset_r, off_s;

  // Decode, stack read port, next-state and retire values.
  always_comb begin
    cur_op_s     = (state_r == S_DECODE) ? op_code : op_r;
    top_idx_s    = IW'(depth_r - D_ONE);
    top_s        = (depth_r == D_ZERO) ? W_ZERO : mem_r[top_idx_s];
    pop_s        = (state_r == S_POP2) || (state_r == S_POP1);
    push_s       = (state_r == S_PUSH);
    state_next_s = S_DECODE;
    push_val_s   = res_r;
    taken_s      = 1'b0;
    off_s        = 16'd1;
    case (state_r)
      S_DECODE: begin
        if (pops_of(cur_op_s) != 2'd0) state_next_s = S_POP2;
        else if (pushes_of(cur_op_s))  state_next_s = S_PUSH;
        else                           state_next_s = S_DONE;
      end
      S_POP2: begin
        if (pops_of(cur_op_s) == 2'd2) state_next_s = S_POP1;
        else if (is_exec(cur_op_s))    state_next_s = S_EXEC;
        else if (pushes_of(cur_op_s))  state_next_s = S_PUSH;
        else                           state_next_s = S_DONE;
      end
      S_POP1: begin
        if (is_exec(cur_op_s))         state_next_s = S_EXEC;
        else if (pushes_of(cur_op_s))  state_next_s = S_PUSH;
        else                           state_next_s = S_DONE;
      end
      S_EXEC:  state_next_s = S_PUSH;
      S_PUSH: begin
        if ((cur_op_s == 8'h5F) && !swap_2nd_r) state_next_s = S_PUSH;
        else                                    state_next_s = S_DONE;
      end
      S_DONE:  state_next_s = S_DECODE;
      default: state_next_s = S_DECODE;
    endcase
    case (cur_op_s)
      8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08:
               push_val_s = {{(DW-8){1'b0}}, cur_op_s} - W_THREE;
      8'h10:   push_val_s = {{(DW-8){arg1[7]}}, arg1};
      8'h11:   push_val_s = {{(DW-16){arg1[7]}}, arg1, arg2};
      8'h59:   push_val_s = top_s;
      8'h5F:   push_val_s = swap_2nd_r ? val1_r : val2_r;
      default: push_val_s = res_r;
    endcase
    // Branch operands: ifeq/ifne resolve in POP2, if_icmp* in POP1 with value1 on the read port.
    case (cur_op_s)
      8'h99:   taken_s = (top_s == W_ZERO);
      8'h9A:   taken_s = (top_s != W_ZERO);
      8'h9F:   taken_s = (top_s == val2_r);
      8'hA0:   taken_s = (top_s != val2_r);
      8'hA1:   taken_s = ($signed(top_s) < $signed(val2_r));
      default: taken_s = 1'b0;
    endcase
    case (cur_op_s)
      8'h10:                              off_s = 16'd2;
      8'h11:                              off_s = 16'd3;
      8'hA7:                              off_s = {arg1, arg2};
      8'h99, 8'h9A, 8'h9F, 8'hA0, 8'hA1:  off_s = taken_s ? {arg1, arg2} : 16'd3;
      default:                            off_s = 16'd1;
    endcase
  end

  // Control state, operand latches, stack pointer and registered retire outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_DECODE;
      op_r       <= 8'h00;
      val1_r     <= W_ZERO;
      val2_r     <= W_ZERO;
      res_r      <= W_ZERO;
      swap_2nd_r <= 1'b0;
      depth_r    <= D_ZERO;
      err_r      <= 1'b0;
      op_done_r  <= 1'b0;
      offset_r   <= 16'd0;
      illegal_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      swap_2nd_r <= push_s && (state_next_s == S_PUSH);
      if (state_r == S_DECODE) op_r   <= op_code;
      if (state_r == S_POP2)   val2_r <= top_s;
      if (state_r == S_POP1)   val1_r <= top_s;
      if (state_r == S_EXEC)   res_r  <= alu(op_r, val1_r, val2_r);
      if (pop_s) begin
        if (depth_r == D_ZERO) err_r   <= 1'b1;
        else                   depth_r <= depth_r - D_ONE;
      end else if (push_s) begin
        if (depth_r == D_FULL) err_r   <= 1'b1;
        else                   depth_r <= depth_r + D_ONE;
      end
      op_done_r <= (state_next_s == S_DONE);
      offset_r  <= (state_next_s == S_DONE) ? off_s : 16'd0;
      illegal_r <= (state_next_s == S_DONE) && !is_legal(cur_op_s);
    end
  end

  // Stack storage; an overflowing push is dropped.
  always_ff @(posedge clk) begin
    if (!rst && push_s && (depth_r != D_FULL)) mem_r[depth_r[IW-1:0]] <= push_val_s;
  end

  assign offset     = offset_r;
  assign op_done    = op_done_r;
  assign illegal_op = illegal_r;
  assign tos        = top_s;
  assign depth      = depth_r;
  assign stack_err  = err_r;

endmodule

// File: tb/tb_jvm_exec_unit.sv
// Directed self-checking bench for jvm_exec_unit: latency, offsets, stack contents,
// overflow/underflow and mid-instruction reset.
module tb_jvm_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  op_code = 8'h00;
  logic [7:0]  arg1 = 8'h00;
  logic [7:0]  arg2 = 8'h00;
  logic [15:0] offset;
  logic        op_done, illegal_op, stack_err;
  logic [31:0] tos;
  logic [4:0]  depth;

  int n_asserts = 0;
  int n_fails   = 0;

  jvm_exec_unit #(.DEPTH(16), .DW(32)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .arg1(arg1), .arg2(arg2),
    .offset(offset), .op_done(op_done), .illegal_op(illegal_op),
    .tos(tos), .depth(depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from the DECODE cycle; returns in the following DECODE cycle.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] a1,
                        input logic [7:0] a2, input int exp_lat, input logic [15:0] exp_off,
                        input logic exp_ill);
    int  cyc;
    logic seen;
    op_code = op; arg1 = a1; arg2 = a2;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (op_done) seen = 1'b1;
    end
    check_eq({tag, ".done"}, 32'(seen), 32'd1);
    if (exp_lat != 0) check_eq({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, ".offset"}, 32'(offset), 32'(exp_off));
    check_eq({tag, ".illegal"}, 32'(illegal_op), 32'(exp_ill));
    @(posedge clk); #1;
    check_eq({tag, ".pulse"}, 32'(op_done), 32'd0);
  endtask

  task automatic check_stack(input string tag, input logic [4:0] exp_depth,
                             input logic [31:0] exp_tos);
    check_eq({tag, ".depth"}, 32'(depth), 32'(exp_depth));
    check_eq({tag, ".tos"}, tos, exp_tos);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check_stack("reset", 5'd0, 32'h0);
    check_eq("reset.op_done", 32'(op_done), 32'd0);
    check_eq("reset.offset", 32'(offset), 32'd0);
    check_eq("reset.illegal", 32'(illegal_op), 32'd0);
    check_eq("reset.err", 32'(stack_err), 32'd0);

    run_op("bipush5", 8'h10, 8'h05, 8'h00, 3, 16'd2, 1'b0);
    check_stack("bipush5", 5'd1, 32'h5);
    run_op("bipushFD", 8'h10, 8'hFD, 8'h00, 3, 16'd2, 1'b0);
    check_stack("bipushFD", 5'd2, 32'hFFFF_FFFD);
    run_op("pop_a", 8'h57, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    check_stack("pop_a", 5'd1, 32'h5);
    run_op("pop_b", 8'h57, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    check_stack("pop_b", 5'd0, 32'h0);

    run_op("iconst3", 8'h06, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    run_op("iconst4", 8'h07, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    run_op("isub", 8'h64, 8'h00, 8'h00, 6, 16'd1, 1'b0);
    check_stack("isub", 5'd1, 32'hFFFF_FFFF);
    run_op("sipush", 8'h11, 8'h7F, 8'hFF, 3, 16'd3, 1'b0);
    check_stack("sipush", 5'd2, 32'h0000_7FFF);
    run_op("iadd", 8'h60, 8'h00, 8'h00, 6, 16'd1, 1'b0);
    check_stack("iadd", 5'd1, 32'h0000_7FFE);
    run_op("pop_c", 8'h57, 8'h00, 8'h00, 3, 16'd1, 1'b0);

    run_op("iconst1", 8'h04, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    run_op("iconst2", 8'h05, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    run_op("icmplt_t", 8'hA1, 8'hFF, 8'hF0, 4, 16'hFFF0, 1'b0);
    check_stack("icmplt_t", 5'd0, 32'h0);
    run_op("iconst2b", 8'h05, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    run_op("iconst1b", 8'h04, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    run_op("icmplt_n", 8'hA1, 8'hFF, 8'hF0, 4, 16'd3, 1'b0);
    check_stack("icmplt_n", 5'd0, 32'h0);

    run_op("goto", 8'hA7, 8'h00, 8'h08, 2, 16'd8, 1'b0);
    run_op("illegal", 8'hFF, 8'h12, 8'h34, 2, 16'd1, 1'b1);
    check_stack("illegal", 5'd0, 32'h0);

    // Extra datapath patterns: ineg, imul, ixor, swap, dup, ifeq/ifne.
    run_op("bipush5b", 8'h10, 8'h05, 8'h00, 3, 16'd2, 1'b0);
    run_op("ineg", 8'h74, 8'h00, 8'h00, 5, 16'd1, 1'b0);
    check_stack("ineg", 5'd1, 32'hFFFF_FFFB);
    run_op("bipush7", 8'h10, 8'h07, 8'h00, 3, 16'd2, 1'b0);
    run_op("imul", 8'h68, 8'h00, 8'h00, 6, 16'd1, 1'b0);
    check_stack("imul", 5'd1, 32'hFFFF_FFDD);
    run_op("sipushF0F", 8'h11, 8'h0F, 8'h0F, 3, 16'd3, 1'b0);
    run_op("ixor", 8'h82, 8'h00, 8'h00, 6, 16'd1, 1'b0);
    check_stack("ixor", 5'd1, 32'hFFFF_F0D2);
    run_op("iconst1c", 8'h04, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    run_op("swap", 8'h5F, 8'h00, 8'h00, 0, 16'd1, 1'b0);
    check_stack("swap", 5'd2, 32'hFFFF_F0D2);
    run_op("pop_d", 8'h57, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    check_stack("pop_d", 5'd1, 32'h1);
    run_op("dup", 8'h59, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    check_stack("dup", 5'd2, 32'h1);
    run_op("ifne_t", 8'h9A, 8'h00, 8'h20, 3, 16'h0020, 1'b0);
    run_op("ifeq_n", 8'h99, 8'h00, 8'h20, 3, 16'd3, 1'b0);
    run_op("iconst0a", 8'h03, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    run_op("ifeq_t0", 8'h99, 8'h00, 8'h00, 3, 16'd0, 1'b0);
    check_stack("ifeq_t0", 5'd0, 32'h0);
    check_eq("pre_ovf.err", 32'(stack_err), 32'd0);

    for (int i = 0; i < 16; i++) run_op("fill", 8'h03, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    check_stack("full", 5'd16, 32'h0);
    check_eq("full.err", 32'(stack_err), 32'd0);
    run_op("ovf", 8'h03, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    check_stack("ovf", 5'd16, 32'h0);
    check_eq("ovf.err", 32'(stack_err), 32'd1);

    do_reset();
    check_eq("rst2.err", 32'(stack_err), 32'd0);
    run_op("pop_empty", 8'h57, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    check_stack("pop_empty", 5'd0, 32'h0);
    check_eq("pop_empty.err", 32'(stack_err), 32'd1);

    // Reset during the EXEC cycle of iadd.
    for (int i = 0; i < 3; i++) run_op("pre_abort", 8'h04, 8'h00, 8'h00, 3, 16'd1, 1'b0);
    op_code = 8'h60;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("abort.no_done", 32'(op_done), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op_code = 8'h00;
    check_eq("abort.op_done", 32'(op_done), 32'd0);
    check_stack("abort", 5'd0, 32'h0);
    check_eq("abort.err", 32'(stack_err), 32'd0);
    run_op("restart_nop", 8'h00, 8'h00, 8'h00, 2, 16'd1, 1'b0);
    check_stack("restart_nop", 5'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
